// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle fetch/decode/execute controller for the 8-bit, 4-register CPU.
// Owns the program counter, the instruction register, the zero flag and the
// single shared memory port (req/ack handshake). The register file and ALU are
// external; this block only drives their addresses, write strobe and op select.
//
// Instruction set (op = instr[7:5]):
//   000 MATH  sub=[4:3] ADD/SUB/INC/DEC, rd=[2:1]  (ADD/SUB: rd op r0)
//   001 XOR / 010 OR / 011 AND   rd=[4:3], rs=[2:1], rd <= rd op rs
//   100 STOP
//   101 LOAD  rd=[4:3], 110 STORE rs=[4:3], 111 JUMP cond=[4:3]
//   LOAD/STORE/JUMP carry a second byte holding an 8-bit address.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               leave IDLE and start fetching at pc
//   mem_req/we/addr     memory request, held stable until the ack cycle
//   mem_ack/rdata       completion strobe and read data
//   rf_ra/rf_rb         register read addresses (port A also feeds STORE data)
//   rf_we/wa/wsel       register write strobe, address, source (1 = mem_rdata)
//   alu_op              0 ADD 1 SUB 2 INC 3 DEC 4 XOR 5 OR 6 AND 7 PASS
//   alu_zero            external ALU result is zero
//   pc, zero_flag       architectural state
//   halted, busy        STOP executed / not in IDLE or HALT
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         NREG     = 4,
    localparam int        RW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_we,
    output logic [7:0]    mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic [RW-1:0] rf_ra,
    output logic [RW-1:0] rf_rb,
    output logic          rf_we,
    output logic [RW-1:0] rf_wa,
    output logic          rf_wsel,
    output logic [2:0]    alu_op,
    input  logic          alu_zero,
    output logic [7:0]    pc,
    output logic          zero_flag,
    output logic          halted,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_MATH  = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_STOP  = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_AND  = 3'd6;
    localparam logic [2:0] ALU_PASS = 3'd7;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    logic [7:0] ir_reg, ir_next;
    logic [7:0] addr_reg, addr_next;
    logic       zero_reg, zero_next;

    // Instruction fields
    logic [2:0]    opcode;
    logic [RW-1:0] fld_hi;      // [4:3]: rd/rs of logic ops, LOAD/STORE reg
    logic [RW-1:0] fld_lo;      // [2:1]: rd of MATH, rs of logic ops
    logic [1:0]    jump_cond;
    logic          jump_taken;
    logic          unused_ir_bit;

    assign opcode        = ir_reg[7:5];
    assign fld_hi        = ir_reg[4:3];
    assign fld_lo        = ir_reg[2:1];
    assign jump_cond     = ir_reg[4:3];
    assign unused_ir_bit = ir_reg[0];

    // cond 00 always, 01 if zero flag, 1x never
    assign jump_taken = (jump_cond == 2'b00) || ((jump_cond == 2'b01) && zero_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= 8'h00;
            addr_reg  <= 8'h00;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            addr_reg  <= addr_next;
            zero_reg  <= zero_next;
        end
    end

    // Memory and register-file strobes are decoded from the state register
    // alone (plus mem_ack for the LOAD write), so an asynchronous reset drops
    // them in the same cycle. When a memory state is followed directly by
    // another memory state, the next request starts the cycle after the ack.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        addr_next  = addr_reg;
        zero_next  = zero_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        rf_ra      = '0;
        rf_rb      = '0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wsel    = 1'b0;
        alu_op     = ALU_PASS;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_reg + 8'd1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_STOP:                     state_next = S_HALT;
                    OP_LOAD, OP_STORE, OP_JUMP:  state_next = S_OPERAND;
                    default:                     state_next = S_EXEC;
                endcase
            end

            S_OPERAND: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
                if (mem_ack) begin
                    addr_next = mem_rdata;
                    pc_next   = pc_reg + 8'd1;
                    if (opcode == OP_JUMP) begin
                        // A taken jump replaces the operand-byte increment.
                        if (jump_taken) begin
                            pc_next = mem_rdata;
                        end
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_MEM;
                    end
                end
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_reg;
                if (opcode == OP_STORE) begin
                    // Write data comes from register read port A.
                    mem_we = 1'b1;
                    rf_ra  = fld_hi;
                end else begin
                    rf_wa   = fld_hi;
                    rf_wsel = 1'b1;
                    rf_we   = mem_ack;
                end
                if (mem_ack) begin
                    state_next = S_FETCH;
                end
            end

            S_EXEC: begin
                rf_we = 1'b1;
                case (opcode)
                    OP_MATH: begin
                        // ADD/SUB take r0 as the second operand; INC/DEC
                        // ignore port B.
                        rf_ra  = fld_lo;
                        rf_rb  = '0;
                        rf_wa  = fld_lo;
                        alu_op = {1'b0, ir_reg[4:3]};
                    end
                    OP_XOR: begin
                        rf_ra  = fld_hi;
                        rf_rb  = fld_lo;
                        rf_wa  = fld_hi;
                        alu_op = ALU_XOR;
                    end
                    OP_OR: begin
                        rf_ra  = fld_hi;
                        rf_rb  = fld_lo;
                        rf_wa  = fld_hi;
                        alu_op = ALU_OR;
                    end
                    default: begin
                        rf_ra  = fld_hi;
                        rf_rb  = fld_lo;
                        rf_wa  = fld_hi;
                        alu_op = ALU_AND;
                    end
                endcase
                zero_next  = alu_zero;
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pc        = pc_reg;
    assign zero_flag = zero_reg;
    assign halted    = (state_reg == S_HALT);
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Wraps cpu_sequencer with a behavioural register file, ALU and 256-byte
// memory with a configurable-latency responder. Each program is first run
// through an instruction-level reference model that produces the expected
// stream of memory transactions and register writes, the final architectural
// state and (for zero-wait memory) the total cycle count.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_rdata;
    logic [1:0] rf_ra, rf_rb, rf_wa;
    logic       rf_we, rf_wsel;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic [7:0] pc;
    logic       zero_flag, halted, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(8'h00), .NREG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wsel   (rf_wsel),
        .alu_op    (alu_op),
        .alu_zero  (alu_zero),
        .pc        (pc),
        .zero_flag (zero_flag),
        .halted    (halted),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- environment: register file, ALU, memory ---------------
    logic [7:0] rf   [4];
    logic [7:0] mem  [256];
    logic [7:0] img  [256];     // program/data image loaded during reset
    logic [7:0] init_r [4];
    logic       load_env = 1'b0;
    logic [7:0] alu_a, alu_b, alu_res;

    always_comb begin
        alu_a = rf[rf_ra];
        alu_b = rf[rf_rb];
        case (alu_op)
            3'd0:    alu_res = alu_a + alu_b;
            3'd1:    alu_res = alu_a - alu_b;
            3'd2:    alu_res = alu_a + 8'd1;
            3'd3:    alu_res = alu_a - 8'd1;
            3'd4:    alu_res = alu_a ^ alu_b;
            3'd5:    alu_res = alu_a | alu_b;
            3'd6:    alu_res = alu_a & alu_b;
            default: alu_res = alu_a;
        endcase
    end
    assign alu_zero = (alu_res == 8'h00);

    always @(posedge clk) begin
        if (load_env) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            for (int i = 0; i < 4; i++) rf[i] <= init_r[i];
        end else begin
            if (rf_we) rf[rf_wa] <= rf_wsel ? mem_rdata : alu_res;
            if (mem_req && mem_ack && mem_we) mem[mem_addr] <= rf[rf_ra];
        end
    end

    // ---------------- expected event stream ----------------------------------
    logic [31:0] exp_q [$];

    function automatic logic [31:0] evt_rd(input logic [7:0] a);
        return {8'd1, a, 16'd0};
    endfunction
    function automatic logic [31:0] evt_wr(input logic [7:0] a, input logic [7:0] d);
        return {8'd2, a, d, 8'd0};
    endfunction
    function automatic logic [31:0] evt_rf(input logic [1:0] wa, input logic [7:0] d, input logic ws);
        return {8'd3, 6'd0, wa, d, 7'd0, ws};
    endfunction

    task automatic log_evt(input logic [31:0] obs);
        logic [31:0] expv;
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("evt", obs, expv);
    endtask

    // ---------------- memory responder + monitor ------------------------------
    // ack_mode: 0 ack one cycle after the request starts, 1 random 0..3 extra
    // wait cycles, 2 three extra wait cycles, 3 as 0 but never ack a read of 80h.
    int         ack_mode = 0;
    int         wait_left = 0;
    bit         in_txn = 1'b0;
    bit         mon_en = 1'b0;
    logic [7:0] txn_addr;
    logic       txn_we;

    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            in_txn  = 1'b0;
        end else if (!in_txn || mem_ack) begin
            in_txn   = 1'b1;
            mem_ack  = 1'b0;
            txn_addr = mem_addr;
            txn_we   = mem_we;
            case (ack_mode)
                1:       wait_left = $urandom_range(0, 3);
                2:       wait_left = 3;
                default: wait_left = 0;
            endcase
        end else if (ack_mode == 3 && !mem_we && mem_addr == 8'h80) begin
            mem_ack = 1'b0;
        end else if (wait_left == 0) begin
            mem_ack = 1'b1;
        end else begin
            wait_left--;
        end
        mem_rdata = mem_ack ? mem[mem_addr] : 8'hA5;
        #1;
        if (mon_en) begin
            if (mem_req && mem_ack) begin
                check("hold", {23'd0, mem_addr, mem_we}, {23'd0, txn_addr, txn_we});
                if (mem_we) begin
                    $display("mem wr addr=%02h data=%02h", mem_addr, rf[rf_ra]);
                    log_evt(evt_wr(mem_addr, rf[rf_ra]));
                end else begin
                    $display("mem rd addr=%02h data=%02h", mem_addr, mem_rdata);
                    log_evt(evt_rd(mem_addr));
                end
            end
            if (rf_we) log_evt(evt_rf(rf_wa, rf_wsel ? mem_rdata : alu_res, rf_wsel));
        end
    end

    // ---------------- instruction-level reference model ----------------------
    logic [7:0] ref_mem [256];
    logic [7:0] ref_r [4];
    logic [7:0] ref_pc;
    logic       ref_z;
    int         ref_cyc;

    task automatic ref_run();
        logic [7:0] ins, a, v;
        logic [1:0] rd, rs;
        ref_pc  = 8'h00;
        ref_z   = 1'b0;
        ref_cyc = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
        for (int i = 0; i < 4; i++) ref_r[i] = init_r[i];
        for (int n = 0; n < 400; n++) begin
            ins = ref_mem[ref_pc];
            exp_q.push_back(evt_rd(ref_pc));
            ref_pc = ref_pc + 8'd1;
            if (ins[7:5] == 3'b100) break;
            a = 8'h00;
            if (ins[7:5] >= 3'b101) begin
                a = ref_mem[ref_pc];
                exp_q.push_back(evt_rd(ref_pc));
                ref_pc = ref_pc + 8'd1;
            end
            case (ins[7:5])
                3'b000: begin
                    rd = ins[2:1];
                    case (ins[4:3])
                        2'd0:    v = ref_r[rd] + ref_r[0];
                        2'd1:    v = ref_r[rd] - ref_r[0];
                        2'd2:    v = ref_r[rd] + 8'd1;
                        default: v = ref_r[rd] - 8'd1;
                    endcase
                    ref_r[rd] = v;
                    ref_z     = (v == 8'h00);
                    exp_q.push_back(evt_rf(rd, v, 1'b0));
                    ref_cyc += 4;
                end
                3'b001, 3'b010, 3'b011: begin
                    rd = ins[4:3];
                    rs = ins[2:1];
                    if (ins[7:5] == 3'b001)      v = ref_r[rd] ^ ref_r[rs];
                    else if (ins[7:5] == 3'b010) v = ref_r[rd] | ref_r[rs];
                    else                         v = ref_r[rd] & ref_r[rs];
                    ref_r[rd] = v;
                    ref_z     = (v == 8'h00);
                    exp_q.push_back(evt_rf(rd, v, 1'b0));
                    ref_cyc += 4;
                end
                3'b101: begin
                    rd = ins[4:3];
                    v  = ref_mem[a];
                    exp_q.push_back(evt_rd(a));
                    exp_q.push_back(evt_rf(rd, v, 1'b1));
                    ref_r[rd] = v;
                    ref_cyc += 7;
                end
                3'b110: begin
                    rs = ins[4:3];
                    exp_q.push_back(evt_wr(a, ref_r[rs]));
                    ref_mem[a] = ref_r[rs];
                    ref_cyc += 7;
                end
                default: begin
                    if (ins[4:3] == 2'b00 || (ins[4:3] == 2'b01 && ref_z)) ref_pc = a;
                    ref_cyc += 5;
                end
            endcase
        end
    endtask

    // ---------------- stimulus helpers ---------------------------------------
    task automatic fill_env();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) init_r[i] = 8'($urandom);
    endtask

    // Random program of forward-only control flow, data in C0..FF, ending in STOP.
    task automatic gen_prog();
        int starts[$];
        int kinds[$];
        int n;
        int a;
        logic [4:0] b5;
        logic [7:0] opnd;
        fill_env();
        n = $urandom_range(6, 20);
        a = 0;
        for (int i = 0; i < n; i++) begin
            kinds.push_back($urandom_range(0, 6));
            starts.push_back(a);
            a += (kinds[i] >= 4) ? 2 : 1;
        end
        starts.push_back(a);
        for (int i = 0; i < n; i++) begin
            b5   = 5'($urandom);
            opnd = 8'($urandom_range(8'hC0, 8'hFF));
            case (kinds[i])
                0: img[starts[i]] = {3'b000, b5};
                1: img[starts[i]] = {3'b001, b5};
                2: img[starts[i]] = {3'b010, b5};
                3: img[starts[i]] = {3'b011, b5};
                4: img[starts[i]] = {3'b101, b5};
                5: img[starts[i]] = {3'b110, b5};
                default: begin
                    img[starts[i]] = {3'b111, b5};
                    opnd = 8'(starts[$urandom_range(i + 1, n)]);
                end
            endcase
            if (kinds[i] >= 4) img[starts[i] + 1] = opnd;
        end
        b5 = 5'($urandom);
        img[a] = {3'b100, b5};
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        load_env = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_env = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check({tag, ":rst"},
              {pc, zero_flag, halted, busy, mem_req, mem_we, rf_we, rf_wsel,
               mem_addr, rf_ra, rf_rb, rf_wa, alu_op},
              32'h0000_0007);
    endtask

    task automatic run_prog(input int mode, input string tag);
        int cyc;
        int nbad;
        ref_run();
        ack_mode = mode;
        do_reset(tag);
        mon_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!halted && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        mon_en = 1'b0;
        check({tag, ":halted"}, {30'd0, halted, busy}, 32'd2);
        if (mode == 0) check({tag, ":cycles"}, cyc, ref_cyc + 4);
        check({tag, ":pc"}, pc, ref_pc);
        check({tag, ":zero"}, zero_flag, ref_z);
        check({tag, ":evt_left"}, exp_q.size(), 0);
        for (int i = 0; i < 4; i++) check({tag, ":reg"}, rf[i], ref_r[i]);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check({tag, ":mem"}, nbad, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ":stay_halted"}, {22'd0, halted, busy, pc}, {22'd0, 1'b1, 1'b0, ref_pc});
        $display("prog %s done cycles=%0d pc=%02h", tag, cyc, pc);
    endtask

    // ---------------- test sequence ------------------------------------------
    initial begin
        bit found;
        rst     = 1'b1;
        start   = 1'b0;
        mem_ack = 1'b0;

        // XOR r3,r1 then STOP
        fill_env();
        img[8'h00] = 8'h3A;
        img[8'h01] = 8'h80;
        run_prog(0, "xor");

        // DEC r1 to zero, then JUMP-if-zero to 40h (taken)
        fill_env();
        img[8'h00] = 8'h1A; img[8'h01] = 8'hE8; img[8'h02] = 8'h40;
        img[8'h03] = 8'h80; img[8'h40] = 8'h80;
        init_r[1] = 8'h01;
        run_prog(0, "jz_taken");

        // Same program with r1=5: zero stays clear, jump falls through
        init_r[1] = 8'h05;
        run_prog(0, "jz_not_taken");

        // Set zero, then LOAD r2 from 80h with slow memory; zero must survive
        fill_env();
        img[8'h00] = 8'h1A; img[8'h01] = 8'hB0; img[8'h02] = 8'h80;
        img[8'h03] = 8'h80; img[8'h80] = 8'h5C;
        init_r[1] = 8'h01;
        run_prog(2, "load_slow");

        // STORE r1 to 10h
        fill_env();
        img[8'h00] = 8'hC8; img[8'h01] = 8'h10; img[8'h02] = 8'h80;
        run_prog(1, "store");

        // Jump to FFh, DEC at FFh wraps pc to 00h, then jump-if-zero to STOP
        fill_env();
        img[8'h00] = 8'hE8; img[8'h01] = 8'h10; img[8'h02] = 8'hE0;
        img[8'h03] = 8'hFF; img[8'hFF] = 8'h1A; img[8'h10] = 8'h80;
        init_r[1] = 8'h01;
        run_prog(0, "pc_wrap");

        // Random programs, alternating zero-wait and random-wait memory
        for (int t = 0; t < 10; t++) begin
            gen_prog();
            run_prog(t % 2, $sformatf("rand%0d", t));
        end

        // Asynchronous reset while a LOAD waits on its data access
        fill_env();
        img[8'h00] = 8'hB0; img[8'h01] = 8'h80; img[8'h02] = 8'h80;
        ack_mode = 3;
        do_reset("rst_mem");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 8'h80) found = 1'b1;
        end
        check("rst_mem:wait", found, 1);
        check("rst_mem:pc_before", pc, 8'h02);
        #2 rst = 1'b1;
        #1;
        check("rst_mem:drop", {19'd0, mem_req, rf_we, busy, halted, pc},
              {19'd0, 4'b0000, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem:idle", {22'd0, busy, mem_req, pc}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 8-bit, 4-register CPU. Owns PC, IR, the zero flag and the single shared memory port (req/ack handshake). Drives register-file read/write addresses and ALU op selects; the register file and ALU stay external. Sits between program/data memory and the datapath.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
NREG, 4, register count (register addresses are 2 bits; fixed)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  leave IDLE and begin fetching at PC
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (STORE)
mem_addr  out  8  memory address
mem_ack  in  1  request completes this cycle; rdata valid
mem_rdata  in  8  read data
rf_ra  out  2  register read port A address
rf_rb  out  2  register read port B address
rf_we  out  1  register write enable (single-cycle pulse)
rf_wa  out  2  register write address
rf_wsel  out  1  0 = write ALU result, 1 = write mem_rdata
alu_op  out  3  0 ADD, 1 SUB, 2 INC, 3 DEC, 4 XOR, 5 OR, 6 AND, 7 PASS
alu_zero  in  1  ALU result == 0
pc  out  8  program counter
zero_flag  out  1  registered zero flag
halted  out  1  STOP executed
busy  out  1  not in IDLE or HALT

Behaviour:
- Encoding: op=instr[7:5]. 000 MATH: sub=[4:3] (ADD,SUB,INC,DEC), rd=[2:1]; ADD/SUB use rd op r0; INC/DEC unary on rd. 001 XOR, 010 OR, 011 AND: rd=[4:3], rs=[2:1], rd <= rd op rs. 100 STOP. 101 LOAD rd=[4:3], 110 STORE rs=[4:3], 111 JUMP cond=[4:3] (00 always, 01 if zero_flag, 1x never). LOAD/STORE/JUMP are two bytes; byte 2 = 8-bit address.
- Reset: state IDLE, pc=RESET_PC, IR=0, zero_flag=0, all strobes 0, halted=0, mem_addr=0, rf_*=0, alu_op=PASS.
- States: IDLE -> FETCH on start. FETCH: mem_req=1, mem_addr=pc; on ack IR<=rdata, pc<=pc+1 (wraps FF->00), -> DECODE. DECODE: MATH/XOR/OR/AND -> EXEC; STOP -> HALT; LOAD/STORE/JUMP -> OPERAND. OPERAND: req at pc; on ack latch address byte, pc<=pc+1; JUMP taken: pc<=address byte (overrides increment) -> FETCH; JUMP not taken -> FETCH; LOAD/STORE -> MEM. MEM: req at latched address, mem_we=1 for STORE with rf_ra=rs (wdata from external reg port A); on ack LOAD pulses rf_we, rf_wsel=1, rf_wa=rd -> FETCH. EXEC: one cycle; rf_ra/rf_rb/alu_op driven, rf_we=1, rf_wsel=0; zero_flag<=alu_zero -> FETCH. HALT: terminal until rst; start ignored.
- zero_flag updates only in EXEC; LOAD/STORE/JUMP never change it.
- Handshake: mem_req, mem_we and mem_addr stable from request until the ack cycle inclusive; mem_req deasserts the cycle after ack. mem_ack while mem_req=0 is ignored. No timeout; waits indefinitely.
- Latency with zero-wait memory (ack 1 cycle after req rises): ALU op 4 cycles, JUMP 5, LOAD/STORE 7, from FETCH entry to next FETCH entry.
- rf_we never asserts outside EXEC or LOAD-MEM ack cycle; at most one pulse per instruction.
- Async rst mid-transaction drops mem_req immediately; no partial writeback.
- busy=1 in FETCH/DECODE/OPERAND/MEM/EXEC.

Test Plan:
- Reset, start, mem 00:8'h3A (XOR r3,r1) ack after 1 cycle -> rf_we one pulse, rf_wa=3, rf_ra=3, rf_rb=1, alu_op=4, pc=01, 4 cycles.
- MATH DEC r1 (8'h1A) with alu_zero=1 -> alu_op=3, rf_wa=1, zero_flag=1; then JUMP-if-zero 8'hE8,8'h40 -> pc=40; with zero_flag=0 -> pc advances by 2.
- LOAD r2 (8'hB0, 8'h80), mem_ack delayed 3 cycles -> mem_addr=80 stable while waiting, rf_we with rf_wsel=1, rf_wa=2 on ack cycle, zero_flag unchanged.
- STORE r1 (8'hC8, 8'h10) -> mem_we=1, mem_addr=10, rf_ra=1, no rf_we.
- pc=FF fetch of 1-byte op -> pc wraps to 00; STOP (8'h80) -> halted=1, busy=0, start ignored.
- rst asserted during MEM wait -> mem_req=0 same cycle, pc=RESET_PC, state IDLE.
